// File: rtl/rfphoenix_vec_wb.sv
// rfphoenix_vec_wb -- vector result writeback sequencer.
//
// Takes one full-width vector result (NLANES lanes) plus a per-lane write
// mask and destination register, and drains it into a narrow register file
// write port PORTS lanes per beat. Lane groups whose mask slice is all zero
// are skipped at no cycle cost. Scalar-target results produce exactly one
// lane-0 beat. A one-cycle done pulse reports completion to issue.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   res_valid/ready    result handshake (ready only while idle)
//   res_data           NLANES*WIDTH result, lane n at [n*WIDTH +: WIDTH]
//   res_mask           per-lane write enable
//   res_rt, res_tt     destination register, 1 = vector / 0 = scalar target
//   wr_stall           register file back-pressure, holds the current beat
//   wr_en/reg/grp/we/data  registered write beat to the register file
//   done_valid/rt      one-cycle completion pulse and its register
module rfphoenix_vec_wb #(
  parameter int NLANES = 16,
  parameter int WIDTH  = 32,
  parameter int PORTS  = 4,
  parameter int RBITS  = 6,
  localparam int NGRP  = NLANES / PORTS,
  localparam int GBITS = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [NLANES*WIDTH-1:0] res_data,
  input  logic [NLANES-1:0]       res_mask,
  input  logic [RBITS-1:0]        res_rt,
  input  logic                    res_tt,
  input  logic                    wr_stall,
  output logic                    wr_en,
  output logic [RBITS-1:0]        wr_reg,
  output logic [GBITS-1:0]        wr_grp,
  output logic [PORTS-1:0]        wr_we,
  output logic [PORTS*WIDTH-1:0]  wr_data,
  output logic                    done_valid,
  output logic [RBITS-1:0]        done_rt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]              r_state;
  logic [NLANES*WIDTH-1:0] r_data;
  logic [NLANES-1:0]       r_mask;
  logic [RBITS-1:0]        r_rt;
  logic                    r_tt;

  logic                    r_ready;
  logic                    r_wr_en;
  logic [RBITS-1:0]        r_wr_reg;
  logic [GBITS-1:0]        r_wr_grp;
  logic [PORTS-1:0]        r_wr_we;
  logic [PORTS*WIDTH-1:0]  r_wr_data;
  logic                    r_done_valid;
  logic [RBITS-1:0]        r_done_rt;

  // Per-group "any lane enabled" flags for the incoming and captured masks.
  logic [NGRP-1:0] w_in_nz;
  logic [NGRP-1:0] w_cap_nz;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_nz
      assign w_in_nz[gi]  = |res_mask[gi*PORTS +: PORTS];
      assign w_cap_nz[gi] = |r_mask[gi*PORTS +: PORTS];
    end
  endgenerate

  // First group to write for a newly offered result, and the next group
  // after the one currently on the port. Scanning high to low leaves the
  // lowest qualifying index in the result.
  logic [GBITS-1:0] w_first_grp;
  logic             w_first_any;
  logic [GBITS-1:0] w_next_grp;
  logic             w_next_any;

  always_comb begin
    w_first_grp = '0;
    w_first_any = 1'b0;
    w_next_grp  = '0;
    w_next_any  = 1'b0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (w_in_nz[g]) begin
        w_first_grp = GBITS'(g);
        w_first_any = 1'b1;
      end
      if (w_cap_nz[g] && (g > int'(r_wr_grp))) begin
        w_next_grp = GBITS'(g);
        w_next_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_mask       <= '0;
      r_rt         <= '0;
      r_tt         <= 1'b0;
      r_ready      <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_reg     <= '0;
      r_wr_grp     <= '0;
      r_wr_we      <= '0;
      r_wr_data    <= '0;
      r_done_valid <= 1'b0;
      r_done_rt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (res_valid) begin
            r_data  <= res_data;
            r_mask  <= res_mask;
            r_rt    <= res_rt;
            r_tt    <= res_tt;
            r_ready <= 1'b0;
            if (!res_tt) begin
              // Scalar target: lane 0 only, mask ignored.
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_reg  <= res_rt;
              r_wr_grp  <= '0;
              r_wr_we   <= PORTS'(1);
              r_wr_data <= (PORTS*WIDTH)'(res_data[WIDTH-1:0]);
            end else if (w_first_any) begin
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_reg  <= res_rt;
              r_wr_grp  <= w_first_grp;
              r_wr_we   <= res_mask[int'(w_first_grp)*PORTS +: PORTS];
              r_wr_data <= res_data[int'(w_first_grp)*PORTS*WIDTH +: PORTS*WIDTH];
            end else begin
              // Nothing to write: report completion straight away.
              r_state      <= ST_DONE;
              r_done_valid <= 1'b1;
              r_done_rt    <= res_rt;
            end
          end
        end

        ST_WRITE: begin
          // A stalled beat simply keeps every wr_* register unchanged.
          if (!wr_stall) begin
            if (r_tt && w_next_any) begin
              r_wr_grp  <= w_next_grp;
              r_wr_we   <= r_mask[int'(w_next_grp)*PORTS +: PORTS];
              r_wr_data <= r_data[int'(w_next_grp)*PORTS*WIDTH +: PORTS*WIDTH];
            end else begin
              r_state      <= ST_DONE;
              r_wr_en      <= 1'b0;
              r_wr_reg     <= '0;
              r_wr_grp     <= '0;
              r_wr_we      <= '0;
              r_wr_data    <= '0;
              r_done_valid <= 1'b1;
              r_done_rt    <= r_rt;
            end
          end
        end

        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_done_valid <= 1'b0;
          r_done_rt    <= '0;
          r_ready      <= 1'b1;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_wr_en      <= 1'b0;
          r_wr_we      <= '0;
          r_done_valid <= 1'b0;
          r_ready      <= 1'b1;
        end
      endcase
    end
  end

  assign res_ready  = r_ready;
  assign wr_en      = r_wr_en;
  assign wr_reg     = r_wr_reg;
  assign wr_grp     = r_wr_grp;
  assign wr_we      = r_wr_we;
  assign wr_data    = r_wr_data;
  assign done_valid = r_done_valid;
  assign done_rt    = r_done_rt;

endmodule

// File: tb/tb_rfphoenix_vec_wb.sv
// Testbench for rfphoenix_vec_wb: directed table of result transactions,
// a mid-operation reset sequence, and randomized transactions, all checked
// cycle by cycle against a beat-list model of the writeback protocol.
module tb_rfphoenix_vec_wb;

  localparam int NLANES = 16;
  localparam int WIDTH  = 32;
  localparam int PORTS  = 4;
  localparam int RBITS  = 6;
  localparam int NGRP   = NLANES / PORTS;
  localparam int GBITS  = 2;

  logic                    clk;
  logic                    rst;
  logic                    res_valid;
  logic                    res_ready;
  logic [NLANES*WIDTH-1:0] res_data;
  logic [NLANES-1:0]       res_mask;
  logic [RBITS-1:0]        res_rt;
  logic                    res_tt;
  logic                    wr_stall;
  logic                    wr_en;
  logic [RBITS-1:0]        wr_reg;
  logic [GBITS-1:0]        wr_grp;
  logic [PORTS-1:0]        wr_we;
  logic [PORTS*WIDTH-1:0]  wr_data;
  logic                    done_valid;
  logic [RBITS-1:0]        done_rt;

  rfphoenix_vec_wb #(
    .NLANES(NLANES), .WIDTH(WIDTH), .PORTS(PORTS), .RBITS(RBITS)
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mask(res_mask), .res_rt(res_rt), .res_tt(res_tt),
    .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_grp(wr_grp), .wr_we(wr_we), .wr_data(wr_data),
    .done_valid(done_valid), .done_rt(done_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lane values for the next transaction.
  logic [WIDTH-1:0] lanes [NLANES];

  typedef struct {
    int                grp;
    logic [PORTS-1:0]  we;
    logic [PORTS*WIDTH-1:0] data;
  } beat_t;
  beat_t obs[$];

  // Drive one result and follow it to completion. The model is the ordered
  // list of groups that must be written; a beat retires on any cycle where
  // the port shows it and the bench holds wr_stall low.
  task automatic do_txn(input logic [RBITS-1:0] rt, input logic [NLANES-1:0] mask,
                        input logic tt, input int stall_grp, input int stall_len,
                        input int pct, input bit hold_valid,
                        output int done_at, output int nbeats, output int beat_cycles);
    int exp_grp[$];
    int idx, stalled, g;
    bit finished, new_beat, s;
    logic [PORTS-1:0] exp_we;
    logic [PORTS*WIDTH-1:0] exp_data;
    exp_grp.delete();
    if (!tt) exp_grp.push_back(0);
    else for (int k = 0; k < NGRP; k++) if (mask[k*PORTS +: PORTS] != '0) exp_grp.push_back(k);

    chk("ready_idle", {255'd0, res_ready}, 256'd1);
    res_valid = 1'b1; res_rt = rt; res_mask = mask; res_tt = tt; wr_stall = 1'b0;
    for (int n = 0; n < NLANES; n++) res_data[n*WIDTH +: WIDTH] = lanes[n];
    obs.delete();
    done_at = -1; nbeats = 0; beat_cycles = 0;
    idx = 0; stalled = 0; finished = 1'b0; new_beat = 1'b1;
    for (int cyc = 1; cyc <= 80 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (hold_valid) begin
        // A competing offer while busy must not be taken.
        res_rt = ~rt; res_tt = 1'b1; res_mask = '1;
      end else begin
        res_valid = 1'b0;
      end
      if (idx < exp_grp.size()) begin
        g = exp_grp[idx];
        if (!tt) begin
          exp_we = 4'b0001;
          exp_data = '0;
          exp_data[WIDTH-1:0] = lanes[0];
        end else begin
          exp_we = mask[g*PORTS +: PORTS];
          for (int k = 0; k < PORTS; k++) exp_data[k*WIDTH +: WIDTH] = lanes[g*PORTS + k];
        end
        chk("wr_en", {255'd0, wr_en}, 256'd1);
        chk("wr_grp", {254'd0, wr_grp}, 256'(g));
        chk("wr_we", {252'd0, wr_we}, {252'd0, exp_we});
        if (!tt) chk("wr_data_lane0", {224'd0, wr_data[WIDTH-1:0]}, {224'd0, exp_data[WIDTH-1:0]});
        else     chk("wr_data", {128'd0, wr_data}, {128'd0, exp_data});
        chk("wr_reg", {250'd0, wr_reg}, {250'd0, rt});
        chk("done_low_in_write", {255'd0, done_valid}, 256'd0);
        chk("ready_low_in_write", {255'd0, res_ready}, 256'd0);
        beat_cycles++;
        if (new_beat) begin
          obs.push_back('{grp: int'(wr_grp), we: wr_we, data: wr_data});
          nbeats++;
        end
        if (g == stall_grp && stalled < stall_len) begin
          s = 1'b1; stalled++;
        end else begin
          s = ($urandom_range(0, 99) < pct);
        end
        wr_stall = s;
        new_beat = !s;
        if (!s) idx++;
      end else begin
        wr_stall = 1'b0;
        chk("done_valid", {255'd0, done_valid}, 256'd1);
        chk("done_rt", {250'd0, done_rt}, {250'd0, rt});
        chk("wr_en_off_in_done", {255'd0, wr_en}, 256'd0);
        chk("wr_we_off_in_done", {252'd0, wr_we}, 256'd0);
        chk("ready_low_in_done", {255'd0, res_ready}, 256'd0);
        done_at = cyc;
        res_valid = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_done", {255'd0, res_ready}, 256'd1);
        chk("done_single_pulse", {255'd0, done_valid}, 256'd0);
        chk("wr_en_idle", {255'd0, wr_en}, 256'd0);
        finished = 1'b1;
      end
    end
    if (!finished) chk("txn_timeout", 256'd0, 256'd1);
    res_valid = 1'b0;
    wr_stall = 1'b0;
  endtask

  typedef struct {
    logic [NLANES-1:0] mask;
    logic [RBITS-1:0]  rt;
    logic              tt;
    logic [WIDTH-1:0]  lane0;
    int                stall_grp;
    int                stall_len;
    bit                hold;
    int                exp_nbeats;
    int                exp_cycles;
    int                exp_done;
    logic [PORTS-1:0]  exp_first_we;
    int                exp_first_grp;
    logic [WIDTH-1:0]  exp_first_lane0;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int done_at, nbeats, cycles;
    logic [PORTS*WIDTH-1:0] grp1_exp;

    tbl[0] = '{16'hFFFF, 6'd5,  1'b1, 32'd100,        -1, 0, 1'b0, 4, 4, 5, 4'hF, 0, 32'd100};
    tbl[1] = '{16'h0F01, 6'd7,  1'b1, 32'd100,        -1, 0, 1'b0, 2, 2, 3, 4'h1, 0, 32'd100};
    tbl[2] = '{16'h0000, 6'd9,  1'b1, 32'd100,        -1, 0, 1'b0, 0, 0, 1, 4'h0, 0, 32'd0};
    tbl[3] = '{16'h0000, 6'd3,  1'b0, 32'hDEADBEEF,   -1, 0, 1'b0, 1, 1, 2, 4'h1, 0, 32'hDEADBEEF};
    tbl[4] = '{16'hFFFF, 6'd11, 1'b1, 32'd100,         1, 3, 1'b1, 4, 7, 8, 4'hF, 0, 32'd100};
    tbl[5] = '{16'hF000, 6'd12, 1'b1, 32'd100,        -1, 0, 1'b0, 1, 1, 2, 4'hF, 3, 32'd112};
    tbl[6] = '{16'hFFFF, 6'd20, 1'b0, 32'h12345678,   -1, 0, 1'b0, 1, 1, 2, 4'h1, 0, 32'h12345678};
    tbl[7] = '{16'h8421, 6'd33, 1'b1, 32'd100,        -1, 0, 1'b1, 4, 4, 5, 4'h1, 0, 32'd100};

    rst = 1'b1; res_valid = 1'b0; res_data = '0; res_mask = '0; res_rt = '0;
    res_tt = 1'b0; wr_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {255'd0, wr_en}, 256'd0);
    chk("rst_done_valid", {255'd0, done_valid}, 256'd0);
    chk("rst_wr_we", {252'd0, wr_we}, 256'd0);
    chk("rst_wr_data", {128'd0, wr_data}, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {255'd0, res_ready}, 256'd1);

    // Directed table.
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < NLANES; n++) lanes[n] = WIDTH'(n + 100);
      lanes[0] = tbl[t].lane0;
      do_txn(tbl[t].rt, tbl[t].mask, tbl[t].tt, tbl[t].stall_grp, tbl[t].stall_len, 0,
             tbl[t].hold, done_at, nbeats, cycles);
      chk($sformatf("t%0d_nbeats", t), 256'(nbeats), 256'(tbl[t].exp_nbeats));
      chk($sformatf("t%0d_beat_cycles", t), 256'(cycles), 256'(tbl[t].exp_cycles));
      chk($sformatf("t%0d_done_at", t), 256'(done_at), 256'(tbl[t].exp_done));
      chk($sformatf("t%0d_first_we", t), {252'd0, (obs.size() > 0) ? obs[0].we : 4'h0},
          {252'd0, tbl[t].exp_first_we});
      chk($sformatf("t%0d_first_grp", t), 256'((obs.size() > 0) ? obs[0].grp : 0),
          256'(tbl[t].exp_first_grp));
      chk($sformatf("t%0d_first_lane0", t),
          {224'd0, (obs.size() > 0) ? obs[0].data[WIDTH-1:0] : 32'd0},
          {224'd0, tbl[t].exp_first_lane0});
      if (t == 0) begin
        grp1_exp = {32'd107, 32'd106, 32'd105, 32'd104};
        chk("full_grp1_data", {128'd0, obs[1].data}, {128'd0, grp1_exp});
      end
      if (t == 1) chk("sparse_second_grp", 256'(obs[1].grp), 256'd2);
      $display("txn %0d: rt=%0d mask=%04h tt=%0b beats=%0d cycles=%0d done_at=%0d",
               t, tbl[t].rt, tbl[t].mask, tbl[t].tt, nbeats, cycles, done_at);
    end

    // Reset in the middle of the grp2 beat abandons the result.
    for (int n = 0; n < NLANES; n++) lanes[n] = WIDTH'(n + 100);
    res_valid = 1'b1; res_rt = 6'd21; res_mask = 16'hFFFF; res_tt = 1'b1;
    for (int n = 0; n < NLANES; n++) res_data[n*WIDTH +: WIDTH] = lanes[n];
    @(posedge clk); #1; res_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_pre_wr_en", {255'd0, wr_en}, 256'd1);
    chk("midrst_pre_grp", {254'd0, wr_grp}, 256'd2);
    rst = 1'b1; #1;
    chk("midrst_wr_en", {255'd0, wr_en}, 256'd0);
    chk("midrst_wr_we", {252'd0, wr_we}, 256'd0);
    chk("midrst_done", {255'd0, done_valid}, 256'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {255'd0, done_valid}, 256'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", {255'd0, res_ready}, 256'd1);
    chk("midrst_idle_no_done", {255'd0, done_valid}, 256'd0);
    do_txn(6'd22, 16'hFFFF, 1'b1, -1, 0, 0, 1'b0, done_at, nbeats, cycles);
    chk("post_rst_done_at", 256'(done_at), 256'd5);
    $display("txn post-reset: rt=22 beats=%0d done_at=%0d", nbeats, done_at);

    // Randomized transactions with random back-pressure.
    for (int t = 0; t < 40; t++) begin
      logic [NLANES-1:0] m;
      logic tt;
      logic [RBITS-1:0] rt;
      int mode;
      mode = $urandom_range(0, 3);
      m = (mode == 0) ? 16'h0000 : (mode == 1) ? 16'hFFFF : NLANES'($urandom);
      tt = ($urandom_range(0, 4) != 0);
      rt = RBITS'($urandom);
      for (int n = 0; n < NLANES; n++) lanes[n] = $urandom;
      do_txn(rt, m, tt, -1, 0, 30, 1'($urandom_range(0, 1)), done_at, nbeats, cycles);
      chk("rand_done_after_beats", 256'(done_at), 256'(cycles + 1));
      $display("txn rand %0d: rt=%0d mask=%04h tt=%0b beats=%0d cycles=%0d done_at=%0d",
               t, rt, m, tt, nbeats, cycles, done_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rfphoenix_vec_wb.md
Name: rfphoenix_vec_wb

Overview:
- Vector result writeback sequencer. It sits between the vector ALU result bus and the vector register file, which has a narrow write port.
- Accepts one full-width vector result (NLANES lanes) with a per-lane write mask and destination register.
- Drains the result into the register file PORTS lanes per cycle, skipping lane groups that are fully masked.
- Scalar-target results (compare to scalar) are written as a single lane-0 beat. Signals completion to the issue logic with a one-cycle done pulse.

Parameters:
NLANES, 16, lanes per vector (power of 2)
WIDTH, 32, bits per lane
PORTS, 4, lanes written per cycle (power of 2, divides NLANES)
RBITS, 6, register number width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
res_valid  input  1  result offered
res_ready  output  1  unit can accept result
res_data  input  NLANES*WIDTH  result; lane n at [n*WIDTH +: WIDTH]
res_mask  input  NLANES  per-lane write enable
res_rt  input  RBITS  destination register
res_tt  input  1  1 = vector target, 0 = scalar target
wr_stall  input  1  register file cannot accept write this cycle
wr_en  output  1  write beat valid
wr_reg  output  RBITS  destination register of beat
wr_grp  output  log2(NLANES/PORTS)  lane group index; lanes grp*PORTS..grp*PORTS+PORTS-1
wr_we  output  PORTS  per-lane enables within group
wr_data  output  PORTS*WIDTH  lane data for group
done_valid  output  1  one-cycle pulse, result fully written
done_rt  output  RBITS  register of completed result

Behaviour:
- Reset: state IDLE. res_ready=1 once out of reset; all other outputs 0. Reset mid-operation abandons the captured result; no done pulse.
- States:
  - IDLE: res_ready=1. On res_valid, capture data/mask/rt/tt.
    - tt=0 -> WRITE with a single beat.
    - tt=1 and mask nonzero -> WRITE at the first group with a nonzero mask.
    - tt=1 and mask all zero -> DONE.
  - WRITE: res_ready=0; wr_en=1.
    - wr_reg = captured rt; wr_we = captured mask slice for the current group; wr_data = captured data slice.
    - wr_stall=1: all wr_* outputs held stable, no advance.
    - wr_stall=0: the beat is written. Advance to the next group with a nonzero mask; if none remain, go to DONE.
    - Scalar target: wr_grp=0, wr_we=one-hot lane 0 regardless of mask, data = captured lane 0, exactly one beat.
  - DONE: done_valid=1 and done_rt=rt for one cycle, then IDLE (res_ready=1 the following cycle).
- Outputs are registered.
  - Accept on cycle N: first beat on cycle N+1. Done pulse occurs the cycle after the last unstalled beat.
  - Full mask, no stalls, NLANES=16, PORTS=4: beats on N+1..N+4, done on N+5, ready on N+6.
- res_valid while res_ready=0 is ignored; the sender holds it.
- Skip logic: the next group is the lowest group index greater than the current one with a nonzero mask slice. Evaluated combinationally from the captured mask, so skipping costs no cycles.
- wr_en=0 in IDLE and DONE; wr_we=0 whenever wr_en=0.

Test Plan:
- Full vector: res_tt=1, mask=16'hFFFF, rt=5, lane n data=n+100, no stall -> 4 beats grp 0..3, wr_we=4'hF, grp1 data {107,106,105,104}; done_valid at N+5 with done_rt=5.
- Sparse mask: mask=16'h0F01 -> 2 beats only: grp0 wr_we=4'b0001, grp2 wr_we=4'hF; done cycle after grp2 beat.
- Zero mask: res_tt=1, mask=0, rt=9 -> no wr_en; done_valid at N+1 with done_rt=9.
- Scalar target: res_tt=0, mask=0, lane0=32'hDEADBEEF, rt=3 -> single beat grp0, wr_we=4'b0001, data lane0=32'hDEADBEEF; done at N+2.
- Stall: full mask, wr_stall=1 for 3 cycles during grp1 -> grp1 outputs held 4 cycles, total 7 beat cycles, done at N+8; res_valid asserted during WRITE is not accepted.
- Reset mid-op: rst asserted during grp2 beat -> wr_en=0, done_valid=0 immediately; res_ready=1 after release; next result processed normally.
